// File: rtl/card_hand_display.sv
// Card hand display: appends card codes into N_SLOTS slots and shows each card plus the hand score on 7-segment digits.
// Optional CARD_BLINK_EN macro blinks the newest card for four half-periods after it is loaded.

module card_glyph (
    input  logic [3:0] code,
    input  logic       digit_mode,
    output logic [6:0] seg
);
    // digit_mode selects numeric glyphs for 0 and 1 (score digit) instead of blank and A
    always_comb begin
        seg = 7'b1111111;
        case (code)
            4'd0:  seg = digit_mode ? 7'b1000000 : 7'b1111111;
            4'd1:  seg = digit_mode ? 7'b1111001 : 7'b0001000;
            4'd2:  seg = 7'b0100100;
            4'd3:  seg = 7'b0110000;
            4'd4:  seg = 7'b0011001;
            4'd5:  seg = 7'b0010010;
            4'd6:  seg = 7'b0000010;
            4'd7:  seg = 7'b1111000;
            4'd8:  seg = 7'b0000000;
            4'd9:  seg = 7'b0010000;
            4'd10: seg = 7'b1000000;
            4'd11: seg = 7'b1100001;
            4'd12: seg = 7'b0011000;
            4'd13: seg = 7'b0001001;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

module card_slot (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       clear,
    input  logic       wr,
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);
    logic [3:0] code_q;
    logic [6:0] glyph;

    // code 0 marks an empty slot and decodes to blank
    always_ff @(posedge slow_clock) begin
        if (!resetb || clear) code_q <= 4'd0;
        else if (wr)          code_q <= code;
    end

    card_glyph u_glyph (.code(code_q), .digit_mode(1'b0), .seg(glyph));

    assign seg = blank ? 7'b1111111 : glyph;
endmodule

module card_hand_display #(
    parameter int N_SLOTS    = 3,
    parameter int BLINK_HALF = 4
) (
    input  logic                         slow_clock,
    input  logic                         resetb,
    input  logic [3:0]                   card_in,
    input  logic                         load_valid,
    input  logic                         clear,
    output logic                         load_ready,
    output logic [7*N_SLOTS-1:0]         HEX,
    output logic [6:0]                   HEX_SCORE,
    output logic [$clog2(N_SLOTS+1)-1:0] count,
    output logic                         err
);
    localparam int CW = $clog2(N_SLOTS+1);

    logic             legal, accept;
    logic [3:0]       score, card_val;
    logic [4:0]       sum;
    logic [6:0]       score_seg;
    logic [N_SLOTS-1:0] slot_wr, slot_blank;

    assign load_ready = (count < CW'(N_SLOTS));
    assign legal      = (card_in >= 4'd1) && (card_in <= 4'd13);
    assign accept     = load_valid && load_ready && !clear && legal;
    assign card_val   = (card_in < 4'd10) ? card_in : 4'd0;
    assign sum        = {1'b0, score} + {1'b0, card_val};

    always_ff @(posedge slow_clock) begin
        if (!resetb || clear) begin
            count <= '0;
            score <= 4'd0;
            err   <= 1'b0;
        end else begin
            err <= load_valid && !accept;
            if (accept) begin
                count <= count + CW'(1);
                score <= (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
            end
        end
    end

`ifdef CARD_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF+1);

    logic          blink_act;
    logic [1:0]    blink_phase;
    logic [BW-1:0] blink_sub;

    // phases 1 and 3 of the four half-periods blank the newest slot
    always_ff @(posedge slow_clock) begin
        if (!resetb || clear) begin
            blink_act   <= 1'b0;
            blink_phase <= 2'd0;
            blink_sub   <= '0;
        end else if (accept) begin
            blink_act   <= 1'b1;
            blink_phase <= 2'd0;
            blink_sub   <= '0;
        end else if (blink_act) begin
            if (blink_sub == BW'(BLINK_HALF-1)) begin
                blink_sub <= '0;
                if (blink_phase == 2'd3) blink_act   <= 1'b0;
                else                     blink_phase <= blink_phase + 2'd1;
            end else begin
                blink_sub <= blink_sub + BW'(1);
            end
        end
    end
`else
    // BLINK_HALF only matters when blinking is built in
    if (BLINK_HALF < 1) begin : g_blink_half_unused
    end
`endif

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign slot_wr[k] = accept && (count == CW'(k));
`ifdef CARD_BLINK_EN
        assign slot_blank[k] = blink_act && blink_phase[0] && (count == CW'(k+1));
`else
        assign slot_blank[k] = 1'b0;
`endif
        card_slot u_slot (
            .slow_clock(slow_clock),
            .resetb    (resetb),
            .clear     (clear),
            .wr        (slot_wr[k]),
            .code      (card_in),
            .blank     (slot_blank[k]),
            .seg       (HEX[7*k +: 7])
        );
    end

    card_glyph u_score (.code(score), .digit_mode(1'b1), .seg(score_seg));

    assign HEX_SCORE = (count == '0) ? 7'b1111111 : score_seg;
endmodule

// File: tb/tb_card_hand_display.sv
// Randomized self-checking bench for card_hand_display against a queue-based hand model.
module tb_card_hand_display;
    localparam int N  = 3;
    localparam int BH = 4;
    localparam int CW = $clog2(N+1);

    logic             slow_clock = 1'b0;
    logic             resetb = 1'b0, load_valid = 1'b0, clear = 1'b0;
    logic [3:0]       card_in = 4'd0;
    logic             load_ready, err;
    logic [7*N-1:0]   HEX;
    logic [6:0]       HEX_SCORE;
    logic [CW-1:0]    count;

    card_hand_display #(.N_SLOTS(N), .BLINK_HALF(BH)) dut (
        .slow_clock(slow_clock), .resetb(resetb), .card_in(card_in),
        .load_valid(load_valid), .clear(clear), .load_ready(load_ready),
        .HEX(HEX), .HEX_SCORE(HEX_SCORE), .count(count), .err(err)
    );

    always #5 slow_clock = ~slow_clock;

    int n_cmp = 0, n_bad = 0;
    int hand[$];
    int m_err = 0;
    int bt = 4*BH;
    logic [6:0] card_g [16];
    logic [6:0] dig_g [10];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7*N-1:0] exp_hex();
        logic [7*N-1:0] h;
        for (int k = 0; k < N; k++) begin
            h[7*k +: 7] = (k < hand.size()) ? card_g[hand[k]] : 7'b1111111;
`ifdef CARD_BLINK_EN
            if (k == hand.size()-1 && bt < 4*BH && ((bt / BH) % 2) == 1)
                h[7*k +: 7] = 7'b1111111;
`endif
        end
        return h;
    endfunction

    function automatic logic [6:0] exp_score();
        int s = 0;
        foreach (hand[i]) s += (hand[i] < 10) ? hand[i] : 0;
        return (hand.size() == 0) ? 7'b1111111 : dig_g[s % 10];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".hex"},   32'(HEX),        32'(exp_hex()));
        chk({tag, ".score"}, 32'(HEX_SCORE),  32'(exp_score()));
        chk({tag, ".count"}, 32'(count),      32'(hand.size()));
        chk({tag, ".ready"}, 32'(load_ready), 32'(hand.size() < N));
        chk({tag, ".err"},   32'(err),        32'(m_err));
    endtask

    // drive inputs, clock one edge, update model, check at the falling edge
    task automatic step(input logic rb, input logic lv, input logic cl, input int cin, input string tag);
        resetb = rb; load_valid = lv; clear = cl; card_in = 4'(cin);
        @(posedge slow_clock);
        if (!rb || cl) begin
            hand.delete(); m_err = 0; bt = 4*BH;
        end else if (lv && hand.size() < N && cin >= 1 && cin <= 13) begin
            hand.push_back(cin); m_err = 0; bt = 0;
        end else begin
            m_err = lv ? 1 : 0;
            if (bt < 4*BH) bt++;
        end
        @(negedge slow_clock);
        check_all(tag);
    endtask

    initial begin
        card_g = '{7'h7f, 7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                   7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b1000000,
                   7'b1100001, 7'b0011000, 7'b0001001, 7'h7f, 7'h7f};
        dig_g  = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        @(negedge slow_clock);
        step(0, 1, 1, 5, "reset");
        chk("reset.hex_all_ones", 32'(HEX), 32'({7*N{1'b1}}));

        // three consecutive loads fill the hand
        step(1, 1, 0, 1, "ld1");
        step(1, 1, 0, 13, "ld13");
        step(1, 1, 0, 9, "ld9");
        step(1, 0, 0, 0, "full");
        chk("full.score_zero", 32'(HEX_SCORE), 32'(7'b1000000));
        chk("full.slot2_9",    32'(HEX[20:14]), 32'(7'b0010000));
        step(1, 1, 0, 5, "overload");
        chk("overload.err", 32'(err), 32'(1));
        step(1, 0, 0, 0, "overload_after");
        chk("overload.err_gone", 32'(err), 32'(0));

        step(1, 0, 1, 0, "clr");
        step(1, 1, 0, 14, "illegal14");
        chk("illegal.count", 32'(count), 32'(0));
        step(1, 0, 0, 0, "illegal_after");

        step(1, 1, 0, 7, "ld7");
        step(1, 1, 0, 8, "ld8");
        chk("78.score5", 32'(HEX_SCORE), 32'(7'b0010010));
        step(1, 1, 1, 2, "clr_over_load");
        chk("clr.hex_blank", 32'(HEX), 32'({7*N{1'b1}}));

        step(1, 1, 0, 3, "ld3");
        step(1, 1, 0, 4, "ld4");
        step(0, 1, 0, 6, "mid_reset");
        step(1, 0, 0, 0, "post_reset");

`ifdef CARD_BLINK_EN
        step(1, 1, 0, 6, "blink_ld6");
        for (int t = 1; t <= 20; t++) step(1, 0, 0, 0, "blink");
        step(1, 0, 1, 0, "blink_clr");
`endif

        // random traffic, clear and reset kept rare so hands fill up
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            step((r < 2) ? 1'b0 : 1'b1, ($urandom_range(0, 9) < 6), (r >= 2 && r < 7),
                 $urandom_range(0, 15), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
